// File: rtl/tlul_copy_pkg.sv
// Shared types and constants for the TL-UL copy engine.
package tlul_copy_pkg;

   typedef enum logic [2:0] {
      CopyIdle,
      CopyRdReq,
      CopyRdRsp,
      CopyWrReq,
      CopyWrRsp,
      CopyDone
   } copy_state_e;

   localparam logic [31:0] CopyWordBytes   = 32'd4;
   localparam logic [3:0]  CopyMaskFull    = 4'hF;
   localparam int unsigned DefaultSourceId = 0;

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL channel types shared by crossbar hosts and devices.
package tlul_pkg;

   typedef enum logic [2:0] {
      PutFullData    = 3'h0,
      PutPartialData = 3'h1,
      Get            = 3'h4
   } tl_a_op_e;

   typedef enum logic [2:0] {
      AccessAck     = 3'h0,
      AccessAckData = 3'h1
   } tl_d_op_e;

   typedef struct packed {
      logic [6:0] cmd_intg;
      logic [6:0] data_intg;
   } tl_a_user_t;

   typedef struct packed {
      logic       a_valid;
      tl_a_op_e   a_opcode;
      logic [2:0] a_param;
      logic [1:0] a_size;
      logic [7:0] a_source;
      logic [31:0] a_address;
      logic [3:0] a_mask;
      logic [31:0] a_data;
      tl_a_user_t a_user;
      logic       d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic       d_valid;
      tl_d_op_e   d_opcode;
      logic [2:0] d_param;
      logic [1:0] d_size;
      logic [7:0] d_source;
      logic       d_sink;
      logic [31:0] d_data;
      logic [6:0] d_user;
      logic       d_error;
      logic       a_ready;
   } tl_d2h_t;

endpackage

// File: rtl/tlul_cmd_intg_gen.sv
// Fills a_user with command and write-data integrity derived from the A-channel fields.
module tlul_cmd_intg_gen
   import tlul_pkg::*;
(
   input  tl_h2d_t tl_i,
   output tl_h2d_t tl_o
);

   function automatic logic [6:0] fold7(input logic [63:0] v);
      return v[6:0] ^ v[13:7] ^ v[20:14] ^ v[27:21] ^ v[34:28] ^ v[41:35] ^
             v[48:42] ^ v[55:49] ^ v[62:56] ^ {6'b0, v[63]};
   endfunction

   logic unused_user;
   assign unused_user = ^tl_i.a_user;

   always_comb begin
      tl_o                  = tl_i;
      tl_o.a_user.cmd_intg  = fold7({25'b0, tl_i.a_opcode, tl_i.a_mask, tl_i.a_address});
      tl_o.a_user.data_intg = fold7({32'b0, tl_i.a_data});
   end

endmodule

// File: rtl/tlul_copy_engine.sv
// TL-UL host that copies len 32-bit words from src to dst, one Get/PutFullData pair per word.
// Optional build macro TLUL_COPY_ERR_ABORT_EN: a d_error response ends the copy immediately.
module tlul_copy_engine
   import tlul_pkg::*;
   import tlul_copy_pkg::*;
#(
   parameter int unsigned SourceId = DefaultSourceId,
   parameter int unsigned LenWidth = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic [31:0]         src_addr_i,
   input  logic [31:0]         dst_addr_i,
   input  logic [LenWidth-1:0] len_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                err_o,
   output logic [LenWidth-1:0] words_done_o,
   output tl_h2d_t             tl_o,
   input  tl_d2h_t             tl_i
);

   localparam logic [7:0] SourceIdBits = 8'(SourceId);

   copy_state_e         state_q, state_d;
   logic [31:0]         src_q, dst_q, data_q;
   logic [LenWidth-1:0] remaining_q, words_done_q;
   logic                err_q;
   logic                start_accept, rd_capture, wr_ack, rsp_err;
   tl_h2d_t             tl_pre;

   logic unused_inputs;
   assign unused_inputs = ^{src_addr_i[1:0], dst_addr_i[1:0], tl_i.d_opcode, tl_i.d_param,
                            tl_i.d_size, tl_i.d_source, tl_i.d_sink, tl_i.d_user};

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= CopyIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d        = state_q;
      start_accept   = 1'b0;
      rd_capture     = 1'b0;
      wr_ack         = 1'b0;
      rsp_err        = 1'b0;
      tl_pre         = '0;
      tl_pre.d_ready = 1'b1;

      unique case (state_q)
         CopyIdle: begin
            if (start_i) begin
               start_accept = 1'b1;
               state_d      = (len_i == '0) ? CopyDone : CopyRdReq;
            end
         end
         CopyRdReq: begin
            tl_pre.a_valid   = 1'b1;
            tl_pre.a_opcode  = Get;
            tl_pre.a_address = src_q;
            if (tl_i.a_ready) state_d = CopyRdRsp;
         end
         CopyRdRsp: begin
            if (tl_i.d_valid) begin
               rsp_err    = tl_i.d_error;
               rd_capture = 1'b1;
               state_d    = CopyWrReq;
`ifdef TLUL_COPY_ERR_ABORT_EN
               if (tl_i.d_error) state_d = CopyDone;
`endif
            end
         end
         CopyWrReq: begin
            tl_pre.a_valid   = 1'b1;
            tl_pre.a_opcode  = PutFullData;
            tl_pre.a_address = dst_q;
            tl_pre.a_data    = data_q;
            if (tl_i.a_ready) state_d = CopyWrRsp;
         end
         CopyWrRsp: begin
            if (tl_i.d_valid) begin
               rsp_err = tl_i.d_error;
               wr_ack  = 1'b1;
               state_d = (remaining_q == LenWidth'(1)) ? CopyDone : CopyRdReq;
`ifdef TLUL_COPY_ERR_ABORT_EN
               if (tl_i.d_error) begin
                  wr_ack  = 1'b0;
                  state_d = CopyDone;
               end
`endif
            end
         end
         CopyDone: state_d = CopyIdle;
         default:  state_d = CopyIdle;
      endcase

      // Fields common to both request kinds; idle cycles keep the whole A channel at zero.
      if (tl_pre.a_valid) begin
         tl_pre.a_size   = 2'd2;
         tl_pre.a_mask   = CopyMaskFull;
         tl_pre.a_source = SourceIdBits;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         src_q        <= '0;
         dst_q        <= '0;
         data_q       <= '0;
         remaining_q  <= '0;
         words_done_q <= '0;
         err_q        <= 1'b0;
      end else begin
         if (start_accept) begin
            src_q        <= {src_addr_i[31:2], 2'b00};
            dst_q        <= {dst_addr_i[31:2], 2'b00};
            remaining_q  <= len_i;
            words_done_q <= '0;
            err_q        <= 1'b0;
         end
         if (rd_capture) data_q <= tl_i.d_data;
         if (wr_ack) begin
            src_q        <= src_q + CopyWordBytes;
            dst_q        <= dst_q + CopyWordBytes;
            remaining_q  <= remaining_q - LenWidth'(1);
            words_done_q <= words_done_q + LenWidth'(1);
         end
         if (rsp_err) err_q <= 1'b1;
      end
   end

   tlul_cmd_intg_gen u_cmd_intg_gen (
      .tl_i (tl_pre),
      .tl_o (tl_o)
   );

   assign busy_o       = (state_q != CopyIdle);
   assign done_o       = (state_q == CopyDone);
   assign err_o        = err_q;
   assign words_done_o = words_done_q;

endmodule

// File: tb/tb_tlul_copy_engine.sv
// Directed + randomized bench for tlul_copy_engine against a word-copy transaction model.
module tb_tlul_copy_engine;
   import tlul_pkg::*;

   localparam int unsigned LW  = 16;
   localparam int unsigned SID = 5;

   logic          clk_i = 1'b0;
   logic          rst_i, start_i;
   logic [31:0]   src_addr_i, dst_addr_i;
   logic [LW-1:0] len_i;
   logic          busy_o, done_o, err_o;
   logic [LW-1:0] words_done_o;
   tl_h2d_t       tl_o;
   tl_d2h_t       tl_i;

   tlul_copy_engine #(.SourceId(SID), .LenWidth(LW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .src_addr_i(src_addr_i),
      .dst_addr_i(dst_addr_i), .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
      .err_o(err_o), .words_done_o(words_done_o), .tl_o(tl_o), .tl_i(tl_i)
   );

   always #5 clk_i = ~clk_i;

   int compared = 0, mismatched = 0;
   int unsigned cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   typedef struct { bit is_put; logic [31:0] addr; logic [31:0] data; } txn_t;
   txn_t log_q[$];
   txn_t exp_q[$];
   logic [31:0] src_mem [logic [31:0]];
   logic [31:0] wr_mem  [logic [31:0]];
   int max_stall = 0, err_rd = 0, rd_base = 0, rd_count = 0;
   int exp_words;

   function automatic logic [31:0] src_rd(input logic [31:0] a);
      return src_mem.exists(a) ? src_mem[a] : (a ^ 32'hA5A5_5A5A);
   endfunction

   // Zero-wait-capable responder with random a_ready stalls and an optional read error.
   initial begin
      bit          pend = 0, pend_err = 0, req_seen = 0;
      logic [31:0] pend_data = '0;
      tl_d_op_e    pend_op = AccessAck;
      tl_h2d_t     held;
      int          stall_left = 0;
      tl_i = '0;
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            pend     = 0;
            req_seen = 0;
         end
         tl_i.d_valid  = pend;
         tl_i.d_data   = pend_data;
         tl_i.d_error  = pend_err;
         tl_i.d_opcode = pend_op;
         tl_i.a_ready  = 1'b0;
         pend          = 0;
         if (!rst_i && tl_o.a_valid) begin
            if (!req_seen) begin
               req_seen   = 1;
               held       = tl_o;
               stall_left = int'($urandom_range(0, max_stall));
            end else begin
               check("stable_addr", tl_o.a_address, held.a_address);
               check("stable_data", tl_o.a_data, held.a_data);
               check("stable_ctl", 32'({tl_o.a_opcode, tl_o.a_mask, tl_o.a_size, tl_o.a_user}),
                     32'({held.a_opcode, held.a_mask, held.a_size, held.a_user}));
            end
            if (stall_left == 0) begin
               tl_i.a_ready = 1'b1;
               req_seen     = 0;
               check("a_mask", 32'(tl_o.a_mask), 32'hF);
               check("a_size_src_param", 32'({tl_o.a_size, tl_o.a_source, tl_o.a_param}),
                     32'({2'd2, 8'(SID), 3'd0}));
               if (tl_o.a_opcode == Get) begin
                  rd_count++;
                  pend_data = src_rd(tl_o.a_address);
                  pend_err  = ((rd_count - rd_base) == err_rd);
                  pend_op   = AccessAckData;
                  log_q.push_back('{1'b0, tl_o.a_address, 32'h0});
               end else begin
                  wr_mem[tl_o.a_address] = tl_o.a_data;
                  pend_data = '0;
                  pend_err  = 0;
                  pend_op   = AccessAck;
                  log_q.push_back('{1'b1, tl_o.a_address, tl_o.a_data});
               end
               pend = 1;
            end else begin
               stall_left--;
            end
         end
      end
   end

   int done_cnt = 0, busy_cnt = 0, av_cnt = 0;
   int unsigned done_cyc = 0;
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (busy_o) busy_cnt++;
         if (tl_o.a_valid) av_cnt++;
      end
   end

   int log_base, done_base, busy_base, av_base;
   int unsigned start_cyc;

   task automatic fill_src(input logic [31:0] src, input int len);
      logic [31:0] a = src & ~32'h3;
      for (int i = 0; i < len; i++) begin
         src_mem[a] = $urandom;
         a += 32'd4;
      end
   endtask

   // Model: word i reads src+4i and writes that word to dst+4i, addresses aligned and wrapping.
   task automatic build_expected(input logic [31:0] src, input logic [31:0] dst,
                                 input int len, input int erd);
      logic [31:0] s = src & ~32'h3;
      logic [31:0] d = dst & ~32'h3;
      exp_q.delete();
      exp_words = len;
      for (int i = 0; i < len; i++) begin
         exp_q.push_back('{1'b0, s, 32'h0});
`ifdef TLUL_COPY_ERR_ABORT_EN
         if (i + 1 == erd) begin
            exp_words = i;
            break;
         end
`endif
         exp_q.push_back('{1'b1, d, src_rd(s)});
         s += 32'd4;
         d += 32'd4;
      end
   endtask

   task automatic start_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                             input int stall, input int erd);
      @(negedge clk_i);
      max_stall  = stall;
      err_rd     = erd;
      rd_base    = rd_count;
      log_base   = log_q.size();
      done_base  = done_cnt;
      busy_base  = busy_cnt;
      av_base    = av_cnt;
      src_addr_i = src;
      dst_addr_i = dst;
      len_i      = LW'(len);
      start_i    = 1'b1;
      start_cyc  = cyc;
      @(negedge clk_i);
      start_i    = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done_cnt == done_base && n < 1000) begin
         @(posedge clk_i);
         n++;
      end
      repeat (4) @(negedge clk_i);
      check({tag, "_done_count"}, done_cnt - done_base, 1);
   endtask

   task automatic compare_log(input string tag);
      check({tag, "_txn_count"}, log_q.size() - log_base, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (log_base + i < log_q.size()) begin
            check($sformatf("%s_kind%0d", tag, i), 32'(log_q[log_base + i].is_put), 32'(exp_q[i].is_put));
            check($sformatf("%s_addr%0d", tag, i), log_q[log_base + i].addr, exp_q[i].addr);
            if (exp_q[i].is_put)
               check($sformatf("%s_data%0d", tag, i), log_q[log_base + i].data, exp_q[i].data);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b1; start_i = 1'b0; src_addr_i = '0; dst_addr_i = '0; len_i = '0;
      repeat (3) @(negedge clk_i);
      check("rst_busy", 32'(busy_o), 0);
      check("rst_done", 32'(done_o), 0);
      check("rst_err", 32'(err_o), 0);
      check("rst_words", 32'(words_done_o), 0);
      check("rst_a_valid", 32'(tl_o.a_valid), 0);
      check("rst_a_addr", tl_o.a_address, 0);
      check("rst_d_ready", 32'(tl_o.d_ready), 1);
      rst_i = 1'b0;

      // len=3, zero-wait responder: done 13 cycles after start.
      fill_src(32'h0010_0000, 3);
      build_expected(32'h0010_0000, 32'h0020_0000, 3, 0);
      start_copy(32'h0010_0000, 32'h0020_0000, 3, 0, 0);
      wait_done("len3");
      compare_log("len3");
      check("len3_latency", done_cyc - start_cyc, 13);
      check("len3_busy_cycles", busy_cnt - busy_base, 13);
      check("len3_words", 32'(words_done_o), 3);
      check("len3_err", 32'(err_o), 0);

      // len=8 with 0-5 cycle a_ready stalls.
      fill_src(32'h0011_0000, 8);
      build_expected(32'h0011_0000, 32'h0021_0000, 8, 0);
      start_copy(32'h0011_0000, 32'h0021_0000, 8, 5, 0);
      wait_done("stall8");
      compare_log("stall8");
      check("stall8_words", 32'(words_done_o), 8);
      foreach (exp_q[i])
         if (exp_q[i].is_put)
            check($sformatf("stall8_mem%0d", i),
                  wr_mem.exists(exp_q[i].addr) ? wr_mem[exp_q[i].addr] : 32'hDEAD_BEEF, exp_q[i].data);

      // len=0: DONE next cycle, no bus traffic.
      start_copy(32'h0012_0000, 32'h0022_0000, 0, 0, 0);
      wait_done("len0");
      check("len0_latency", done_cyc - start_cyc, 1);
      check("len0_a_valid_cycles", av_cnt - av_base, 0);
      check("len0_busy_cycles", busy_cnt - busy_base, 1);
      check("len0_words", 32'(words_done_o), 0);

      // Read 2 of 4 returns d_error.
      fill_src(32'h0013_0000, 4);
      build_expected(32'h0013_0000, 32'h0023_0000, 4, 2);
      start_copy(32'h0013_0000, 32'h0023_0000, 4, 0, 2);
      wait_done("rderr");
      compare_log("rderr");
      check("rderr_err", 32'(err_o), 1);
      check("rderr_words", 32'(words_done_o), 32'(exp_words));

      // A clean copy after an error clears err_o; unaligned inputs are word-aligned.
      fill_src(32'h0014_0000, 2);
      build_expected(32'h0014_0003, 32'h0024_0001, 2, 0);
      start_copy(32'h0014_0003, 32'h0024_0001, 2, 1, 0);
      wait_done("clean");
      compare_log("clean");
      check("clean_err_cleared", 32'(err_o), 0);

      // Source address wraps past 2^32.
      fill_src(32'hFFFF_FFFC, 2);
      build_expected(32'hFFFF_FFFC, 32'h0000_1000, 2, 0);
      start_copy(32'hFFFF_FFFC, 32'h0000_1000, 2, 0, 0);
      wait_done("wrap");
      compare_log("wrap");
      check("wrap_second_get", (log_q.size() > log_base + 2) ? log_q[log_base + 2].addr : 32'hFFFF_FFFF, 0);

      // Randomized copies with random stalls and addresses.
      for (int r = 0; r < 4; r++) begin
         logic [31:0] s = $urandom;
         int          l = int'($urandom_range(1, 6));
         fill_src(s, l);
         build_expected(s, s ^ 32'h8000_0000, l, 0);
         start_copy(s, s ^ 32'h8000_0000, l, int'($urandom_range(0, 3)), 0);
         wait_done($sformatf("rand%0d", r));
         compare_log($sformatf("rand%0d", r));
         check($sformatf("rand%0d_words", r), 32'(words_done_o), 32'(l));
      end

      // Reset while the second write is on the bus.
      begin
         int n = 0;
         fill_src(32'h0030_0000, 4);
         start_copy(32'h0030_0000, 32'h0040_0000, 4, 0, 0);
         while (!(tl_o.a_valid && tl_o.a_opcode == PutFullData && tl_o.a_address == 32'h0040_0004)
                && n < 200) begin
            @(negedge clk_i);
            n++;
         end
         check("rst_mid_wr2_reached", 32'(n < 200), 1);
         rst_i = 1'b1;
         @(negedge clk_i);
         check("rst_mid_a_valid", 32'(tl_o.a_valid), 0);
         check("rst_mid_busy", 32'(busy_o), 0);
         check("rst_mid_done", 32'(done_o), 0);
         check("rst_mid_words", 32'(words_done_o), 0);
         check("rst_mid_a_addr", tl_o.a_address, 0);
         check("rst_mid_d_ready", 32'(tl_o.d_ready), 1);
         @(negedge clk_i);
         rst_i = 1'b0;
      end

      // start_i while busy is ignored.
      fill_src(32'h0050_0000, 3);
      build_expected(32'h0050_0000, 32'h0060_0000, 3, 0);
      start_copy(32'h0050_0000, 32'h0060_0000, 3, 0, 0);
      repeat (2) @(negedge clk_i);
      src_addr_i = 32'h0070_0000;
      dst_addr_i = 32'h0080_0000;
      len_i      = LW'(5);
      start_i    = 1'b1;
      repeat (2) @(negedge clk_i);
      start_i    = 1'b0;
      wait_done("busystart");
      compare_log("busystart");
      check("busystart_words", 32'(words_done_o), 3);
      check("busystart_latency", done_cyc - start_cyc, 13);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
